// File: rtl/controlador_operacoes_matriz_if.sv
// Command, memory and operation-unit bundle for the 5x5 int8 matrix sequencer.
// master = controller side, slave = environment (host, row memory, operation unit).
interface controlador_operacoes_matriz_if #(
  parameter int LARGURA_END = 8
);
  logic                   cmd_valido;
  logic                   cmd_pronto;
  logic [2:0]             cmd_operacao;
  logic [LARGURA_END-1:0] cmd_end_a;
  logic [LARGURA_END-1:0] cmd_end_b;
  logic [LARGURA_END-1:0] cmd_end_r;
  logic [7:0]             cmd_escalar;

  logic [LARGURA_END-1:0] mem_end;
  logic                   mem_le;
  logic [39:0]            mem_dado_lido;
  logic                   mem_escreve;
  logic [39:0]            mem_dado_escrita;

  logic [2:0]             op_operacao;
  logic [199:0]           op_matriz_a;
  logic [199:0]           op_matriz_b;
  logic [7:0]             op_escalar;
  logic [199:0]           op_resultado;

  logic                   ocupado;
  logic                   concluido;
  logic                   erro;

  modport master (
    input  cmd_valido, cmd_operacao, cmd_end_a, cmd_end_b, cmd_end_r, cmd_escalar,
    input  mem_dado_lido, op_resultado,
    output cmd_pronto, mem_end, mem_le, mem_escreve, mem_dado_escrita,
    output op_operacao, op_matriz_a, op_matriz_b, op_escalar,
    output ocupado, concluido, erro
  );

  modport slave (
    output cmd_valido, cmd_operacao, cmd_end_a, cmd_end_b, cmd_end_r, cmd_escalar,
    output mem_dado_lido, op_resultado,
    input  cmd_pronto, mem_end, mem_le, mem_escreve, mem_dado_escrita,
    input  op_operacao, op_matriz_a, op_matriz_b, op_escalar,
    input  ocupado, concluido, erro
  );
endinterface

// File: rtl/controlador_operacoes_matriz.sv
// Sequencer for the 5x5 int8 matrix unit: fetch rows, run the unit, write back, pulse concluido.
// Optional CTRL_FILA_CMD_EN adds a one-entry command buffer so a command can queue while busy.
module controlador_operacoes_matriz #(
  parameter int LARGURA_END = 8,
  parameter int LAT_OP      = 1,
  parameter int LAT_MULT    = 2
) (
  input logic clk,
  input logic rst_n,
  controlador_operacoes_matriz_if.master bus
);

  typedef enum logic [2:0] {
    OCIOSO, LE_A, LE_B, CAPTURA, EXECUTA, ESCREVE, CONCLUIDO
  } estado_t;

  typedef struct packed {
    logic [2:0]             op;
    logic [LARGURA_END-1:0] end_a;
    logic [LARGURA_END-1:0] end_b;
    logic [LARGURA_END-1:0] end_r;
    logic [7:0]             escalar;
  } cmd_t;

  estado_t      estado, estado_nxt;
  cmd_t         cmd_atual, cmd_entrada, cmd_inicio;
  logic         inicia, aceita, binaria;
  logic [7:0]   cnt, lat_alvo;
  logic [199:0] mat_a, mat_b, mat_a_nxt, mat_b_nxt, resultado;
  logic         leitura_pend, leitura_b;
  logic [2:0]   leitura_idx;

  assign cmd_entrada = {bus.cmd_operacao, bus.cmd_end_a, bus.cmd_end_b,
                        bus.cmd_end_r, bus.cmd_escalar};
  assign aceita      = bus.cmd_valido && bus.cmd_pronto;
  assign binaria     = (cmd_atual.op == 3'd0) || (cmd_atual.op == 3'd1) ||
                       (cmd_atual.op == 3'd5);
  assign lat_alvo    = (cmd_atual.op == 3'd5) ? 8'(LAT_MULT) : 8'(LAT_OP);

`ifdef CTRL_FILA_CMD_EN
  logic fila_valida;
  cmd_t fila;
  assign bus.cmd_pronto = !fila_valida;
`else
  assign bus.cmd_pronto = (estado == OCIOSO);
`endif

  assign bus.ocupado   = (estado != OCIOSO);
  assign bus.concluido = (estado == CONCLUIDO);
  assign bus.erro      = (estado == CONCLUIDO) && (cmd_atual.op >= 3'd6);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    estado_nxt = estado;
    inicia     = 1'b0;
    cmd_inicio = cmd_entrada;
    case (estado)
      OCIOSO:    if (aceita) inicia = 1'b1;
      LE_A:      if (cnt == 8'd4) estado_nxt = binaria ? LE_B : CAPTURA;
      LE_B:      if (cnt == 8'd4) estado_nxt = CAPTURA;
      CAPTURA:   estado_nxt = EXECUTA;
      EXECUTA:   if (cnt == lat_alvo - 8'd1) estado_nxt = ESCREVE;
      ESCREVE:   if (cnt == 8'd4) estado_nxt = CONCLUIDO;
      CONCLUIDO: begin
        estado_nxt = OCIOSO;
`ifdef CTRL_FILA_CMD_EN
        if (fila_valida) begin
          inicia     = 1'b1;
          cmd_inicio = fila;
        end else if (aceita) begin
          inicia = 1'b1;
        end
`endif
      end
      default:   estado_nxt = OCIOSO;
    endcase
    // Illegal opcodes skip all memory traffic and report straight away.
    if (inicia) estado_nxt = (cmd_inicio.op >= 3'd6) ? CONCLUIDO : LE_A;
  end

  always_comb begin
    bus.mem_le           = 1'b0;
    bus.mem_escreve      = 1'b0;
    bus.mem_end          = '0;
    bus.mem_dado_escrita = '0;
    case (estado)
      LE_A: begin
        bus.mem_le  = 1'b1;
        bus.mem_end = cmd_atual.end_a + LARGURA_END'(cnt[2:0]);
      end
      LE_B: begin
        bus.mem_le  = 1'b1;
        bus.mem_end = cmd_atual.end_b + LARGURA_END'(cnt[2:0]);
      end
      ESCREVE: begin
        bus.mem_escreve      = 1'b1;
        bus.mem_end          = cmd_atual.end_r + LARGURA_END'(cnt[2:0]);
        bus.mem_dado_escrita = resultado[40*int'(cnt[2:0]) +: 40];
      end
      default: ;
    endcase
  end

  // Read data returns one cycle after the strobe; the delayed tag says where it lands.
  always_comb begin
    mat_a_nxt = mat_a;
    mat_b_nxt = mat_b;
    if (leitura_pend) begin
      if (leitura_b) mat_b_nxt[40*int'(leitura_idx) +: 40] = bus.mem_dado_lido;
      else           mat_a_nxt[40*int'(leitura_idx) +: 40] = bus.mem_dado_lido;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estado          <= OCIOSO;
      cnt             <= '0;
      cmd_atual       <= '0;
      leitura_pend    <= 1'b0;
      leitura_b       <= 1'b0;
      leitura_idx     <= '0;
      // NOTE: the operand/result registers are plain flops, so they are cleared here too.
      mat_a           <= '0;
      mat_b           <= '0;
      resultado       <= '0;
      bus.op_operacao <= '0;
      bus.op_escalar  <= '0;
      bus.op_matriz_a <= '0;
      bus.op_matriz_b <= '0;
`ifdef CTRL_FILA_CMD_EN
      fila_valida     <= 1'b0;
      fila            <= '0;
`endif
    end else begin
      estado       <= estado_nxt;
      cnt          <= (estado_nxt != estado) ? 8'd0 : cnt + 8'd1;
      leitura_pend <= bus.mem_le;
      leitura_b    <= (estado == LE_B);
      leitura_idx  <= cnt[2:0];
      mat_a        <= mat_a_nxt;
      mat_b        <= mat_b_nxt;
      if (inicia) cmd_atual <= cmd_inicio;
      // Operands are frozen on entry to EXECUTA, including the row returning this cycle.
      if (estado == CAPTURA) begin
        bus.op_operacao <= cmd_atual.op;
        bus.op_escalar  <= cmd_atual.escalar;
        bus.op_matriz_a <= mat_a_nxt;
        bus.op_matriz_b <= mat_b_nxt;
      end
      if ((estado == EXECUTA) && (estado_nxt == ESCREVE)) resultado <= bus.op_resultado;
`ifdef CTRL_FILA_CMD_EN
      if ((estado == CONCLUIDO) && fila_valida) begin
        fila_valida <= 1'b0;
      end else if (aceita && (estado != OCIOSO) && (estado != CONCLUIDO)) begin
        fila        <= cmd_entrada;
        fila_valida <= 1'b1;
      end
`endif
    end
  end

endmodule

// File: tb/tb_controlador_operacoes_matriz.sv
// Directed bench for controlador_operacoes_matriz: row memory model, operation unit model
// with a latency guard for matmul, and hand-computed expected rows and cycle counts.
module tb_controlador_operacoes_matriz;
  localparam int LE = 8;
`ifdef CTRL_FILA_CMD_EN
  localparam bit FILA = 1'b1;
`else
  localparam bit FILA = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  controlador_operacoes_matriz_if #(.LARGURA_END(LE)) bus ();

  controlador_operacoes_matriz #(.LARGURA_END(LE), .LAT_OP(1), .LAT_MULT(2)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Row memory: preloaded on the first clock, read data registered one cycle after mem_le.
  logic [39:0] mem [256];
  logic mem_pronta = 1'b0;
  int rd_count = 0, wr_count = 0, both_count = 0;

  function automatic logic [39:0] init_row(int a);
    logic [39:0] r = '0;
    if (a < 5)                       r = {5{8'h01}};
    else if (a < 10)                 r = {5{8'h02}};
    else if (a >= 30 && a < 35)      for (int j = 0; j < 5; j++) r[8*j +: 8] = 8'(5*(a-30) + j);
    else if (a >= 50 && a < 55)      r = {5{8'h64}};
    else if (a >= 70 && a < 75)      r[8*(a-70) +: 8] = 8'h01;
    return r;
  endfunction

  always @(posedge clk) begin
    if (!mem_pronta) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_row(i);
      mem_pronta <= 1'b1;
    end else begin
      if (bus.mem_le) begin
        bus.mem_dado_lido <= mem[bus.mem_end];
        rd_count <= rd_count + 1;
      end
      if (bus.mem_escreve) begin
        mem[bus.mem_end] <= bus.mem_dado_escrita;
        wr_count <= wr_count + 1;
      end
      if (bus.mem_le && bus.mem_escreve) both_count <= both_count + 1;
    end
  end

  // Operation unit: matmul output is garbage until operands have been stable for a cycle.
  function automatic int el(logic [199:0] m, int i, int j);
    return int'($signed(m[8*(5*i+j) +: 8]));
  endfunction

  function automatic logic [199:0] unit_f(logic [2:0] op, logic [7:0] s,
                                          logic [199:0] a, logic [199:0] b);
    logic [199:0] r = '0;
    int x;
    for (int i = 0; i < 5; i++)
      for (int j = 0; j < 5; j++) begin
        case (op)
          3'd0: x = el(a, i, j) + el(b, i, j);
          3'd1: x = el(a, i, j) - el(b, i, j);
          3'd2: x = el(a, i, j) * int'($signed(s));
          3'd3: x = -el(a, i, j);
          3'd4: x = el(a, j, i);
          3'd5: begin
            x = 0;
            for (int k = 0; k < 5; k++) x += el(a, i, k) * el(b, k, j);
          end
          default: x = 0;
        endcase
        r[8*(5*i+j) +: 8] = x[7:0];
      end
    return r;
  endfunction

  logic [410:0] op_prev = '0;
  int estavel = 0;
  always @(negedge clk) begin
    if ({bus.op_operacao, bus.op_escalar, bus.op_matriz_a, bus.op_matriz_b} == op_prev)
      estavel <= estavel + 1;
    else
      estavel <= 0;
    op_prev <= {bus.op_operacao, bus.op_escalar, bus.op_matriz_a, bus.op_matriz_b};
  end

  assign bus.op_resultado = (bus.op_operacao == 3'd5 && estavel < 1) ? '1 :
      unit_f(bus.op_operacao, bus.op_escalar, bus.op_matriz_a, bus.op_matriz_b);

  logic [7:0] snap_esc [64];
  logic [2:0] snap_op  [64];

  // Cycle 1 is the cycle right after the accepting edge; returns the concluido cycle.
  task automatic run_cmd(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] r, input logic [7:0] esc,
                         output int ciclo, output logic erro_v);
    @(negedge clk);
    check("pronto_antes_cmd", bus.cmd_pronto, 1);
    bus.cmd_valido   = 1'b1;
    bus.cmd_operacao = op;
    bus.cmd_end_a    = a;
    bus.cmd_end_b    = b;
    bus.cmd_end_r    = r;
    bus.cmd_escalar  = esc;
    @(posedge clk);
    #1 bus.cmd_valido = 1'b0;
    ciclo  = -1;
    erro_v = 1'b0;
    for (int n = 1; n < 64; n++) begin
      @(negedge clk);
      snap_esc[n] = bus.op_escalar;
      snap_op[n]  = bus.op_operacao;
      if (bus.concluido) begin
        ciclo  = n;
        erro_v = bus.erro;
        break;
      end
    end
  endtask

  function automatic logic [39:0] linha_transposta(int i);
    logic [39:0] r = '0;
    for (int j = 0; j < 5; j++) r[8*j +: 8] = 8'(5*j + i);
    return r;
  endfunction

  int c, rd0, wr0;
  logic e;
  int conc1, conc2, acc2, le2;
  logic oc_after;

  initial begin
    bus.cmd_valido = 1'b0; bus.cmd_operacao = '0; bus.cmd_escalar = '0;
    bus.cmd_end_a = '0; bus.cmd_end_b = '0; bus.cmd_end_r = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cmd_pronto", bus.cmd_pronto, 1);
    check("rst_ocupado", bus.ocupado, 0);
    check("rst_concluido", bus.concluido, 0);
    check("rst_erro", bus.erro, 0);
    check("rst_strobes", {bus.mem_le, bus.mem_escreve}, 0);
    check("rst_op_a", |bus.op_matriz_a, 0);
    @(negedge clk) rst_n = 1'b1;

    // add: all 1 + all 2 -> all 3 at rows 16-20
    rd0 = rd_count; wr0 = wr_count;
    run_cmd(3'd0, 8'd0, 8'd5, 8'd16, 8'd0, c, e);
    check("add_latencia", c, 18);
    check("add_erro", e, 0);
    check("add_leituras", rd_count - rd0, 10);
    check("add_escritas", wr_count - wr0, 5);
    for (int i = 0; i < 5; i++) check($sformatf("add_linha%0d", i), mem[16+i], {5{8'h03}});

    // transpose: never touches end_b
    rd0 = rd_count;
    run_cmd(3'd4, 8'd30, 8'd100, 8'd40, 8'd0, c, e);
    check("transp_latencia", c, 13);
    check("transp_leituras", rd_count - rd0, 5);
    for (int i = 0; i < 5; i++) check($sformatf("transp_linha%0d", i), mem[40+i], linha_transposta(i));

    // scalar multiply: 100*2 wraps to 0xC8
    run_cmd(3'd2, 8'd50, 8'd0, 8'd60, 8'd2, c, e);
    check("escalar_latencia", c, 13);
    check("escalar_op_escalar", snap_esc[7], 8'd2);
    check("escalar_op_operacao", snap_op[7], 3'd2);
    for (int i = 0; i < 5; i++) check($sformatf("escalar_linha%0d", i), mem[60+i], {5{8'hC8}});

    // illegal opcode
    rd0 = rd_count; wr0 = wr_count;
    run_cmd(3'd7, 8'd0, 8'd5, 8'd200, 8'd0, c, e);
    check("ilegal_latencia", c, 1);
    check("ilegal_erro", e, 1);
    check("ilegal_acessos", (rd_count - rd0) + (wr_count - wr0), 0);

    // matmul by identity reproduces A; needs the 2-cycle wait
    run_cmd(3'd5, 8'd30, 8'd70, 8'd80, 8'd0, c, e);
    check("matmul_latencia", c, 19);
    for (int i = 0; i < 5; i++) check($sformatf("matmul_linha%0d", i), mem[80+i], init_row(30+i));

    // back-to-back: add to 120, then transpose to 110
    @(negedge clk);
    bus.cmd_valido = 1'b1; bus.cmd_operacao = 3'd0;
    bus.cmd_end_a = 8'd0; bus.cmd_end_b = 8'd5; bus.cmd_end_r = 8'd120;
    @(posedge clk);
    #1 bus.cmd_operacao = 3'd4; bus.cmd_end_a = 8'd30; bus.cmd_end_r = 8'd110;
    conc1 = -1; conc2 = -1; acc2 = -1; le2 = -1; oc_after = 1'bx;
    for (int n = 1; n < 80; n++) begin
      @(negedge clk);
      if (n == 1) check("b2b_pronto_ocupado", bus.cmd_pronto, FILA);
      if (acc2 < 0 && bus.cmd_valido && bus.cmd_pronto) acc2 = n;
      else if (acc2 >= 0) bus.cmd_valido = 1'b0;
      if (conc1 >= 0 && n == conc1 + 1) oc_after = bus.ocupado;
      if (conc1 >= 0 && n > conc1 && le2 < 0 && bus.mem_le) le2 = n;
      if (bus.concluido) begin
        if (conc1 < 0) conc1 = n;
        else conc2 = n;
      end
      if (conc2 >= 0) break;
    end
    bus.cmd_valido = 1'b0;
    check("b2b_conc1", conc1, 18);
    check("b2b_aceite2", acc2, FILA ? 1 : 19);
    check("b2b_primeiro_le2", le2, FILA ? 19 : 20);
    check("b2b_ocupado_apos", oc_after, FILA);
    check("b2b_conc2", conc2, FILA ? 31 : 32);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("b2b_add_linha%0d", i), mem[120+i], {5{8'h03}});
      check($sformatf("b2b_transp_linha%0d", i), mem[110+i], linha_transposta(i));
    end

    // reset during the 3rd write cycle
    @(negedge clk);
    bus.cmd_valido = 1'b1; bus.cmd_operacao = 3'd4;
    bus.cmd_end_a = 8'd30; bus.cmd_end_r = 8'd90;
    @(posedge clk);
    #1 bus.cmd_valido = 1'b0;
    wr0 = wr_count;
    repeat (9) @(posedge clk);
    #2;
    check("rstw_escrevendo", {bus.mem_escreve, bus.mem_end}, {1'b1, 8'd92});
    rst_n = 1'b0;
    #1;
    check("rstw_strobes", {bus.mem_le, bus.mem_escreve}, 0);
    check("rstw_pronto", bus.cmd_pronto, 1);
    check("rstw_status", {bus.ocupado, bus.concluido, bus.erro}, 0);
    check("rstw_saidas", {|bus.op_matriz_a, |bus.op_matriz_b, |bus.op_escalar,
                          |bus.mem_dado_escrita, |bus.mem_end}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("rstw_escritas", wr_count - wr0, 2);
    check("rstw_linha1", mem[91], linha_transposta(1));
    check("rstw_linha2_intacta", mem[92], 40'h0);
    check("rstw_ocioso", bus.ocupado, 0);

    // subtract with result address wrapping 254..2
    run_cmd(3'd1, 8'd0, 8'd5, 8'd254, 8'd0, c, e);
    check("wrap_latencia", c, 18);
    for (int i = 0; i < 5; i++)
      check($sformatf("wrap_linha%0d", i), mem[8'(254+i)], {5{8'hFF}});

    check("strobes_simultaneos", both_count, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
